// File: rtl/axi_ram_slave.sv
// AXI4 slave backed by an on-chip word-addressed RAM; serves one write or read
// burst at a time (FIXED/INCR/WRAP, 1-256 beats of 32 bits).
module axi_ram_slave #(
    parameter int ADDR_WIDTH = 12,
    parameter int ID_WIDTH   = 4
) (
    input  logic                cpu_clk_50M,
    input  logic                cpu_rst_n,
    input  logic [ID_WIDTH-1:0] s_awid,
    input  logic [31:0]         s_awaddr,
    input  logic [7:0]          s_awlen,
    input  logic [2:0]          s_awsize,
    input  logic [1:0]          s_awburst,
    input  logic                s_awlock,
    input  logic [3:0]          s_awcache,
    input  logic [2:0]          s_awprot,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [ID_WIDTH-1:0] s_wid,
    input  logic [31:0]         s_wdata,
    input  logic [3:0]          s_wstrb,
    input  logic                s_wlast,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [ID_WIDTH-1:0] s_bid,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ID_WIDTH-1:0] s_arid,
    input  logic [31:0]         s_araddr,
    input  logic [7:0]          s_arlen,
    input  logic [2:0]          s_arsize,
    input  logic [1:0]          s_arburst,
    input  logic                s_arlock,
    input  logic [3:0]          s_arcache,
    input  logic [2:0]          s_arprot,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [ID_WIDTH-1:0] s_rid,
    output logic [31:0]         s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                s_rvalid,
    input  logic                s_rready
);

    typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [31:0]           r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [1:0]            r_burst;
    logic [7:0]            r_cnt;
    logic [ID_WIDTH-1:0]   r_id;
    logic                  r_err;
    logic                  r_prio_rd;
    logic [31:0]           r_rdata;

    logic                  w_grant_rd;
    logic                  w_aw_hs;
    logic                  w_ar_hs;
    logic                  w_w_hs;
    logic                  w_r_hs;
    logic                  w_last_beat;
    logic                  w_ren;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic                  w_unused;

    // WRAP keeps the upper address bits and wraps the low log2(len+1) bits;
    // an illegal WRAP length (or reserved burst code) falls back to INCR.
    function automatic logic [ADDR_WIDTH-1:0] f_next_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [7:0]            len,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] inc;
        mask = ADDR_WIDTH'(len[3:0]);
        inc  = a + ADDR_WIDTH'(1);
        if (burst == 2'b00)
            f_next_addr = a;
        else if (burst == 2'b10 &&
                 (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            f_next_addr = (a & ~mask) | (inc & mask);
        else
            f_next_addr = inc;
    endfunction

    assign w_grant_rd  = s_arvalid && (!s_awvalid || r_prio_rd);
    assign w_aw_hs     = s_awvalid && s_awready;
    assign w_ar_hs     = s_arvalid && s_arready;
    assign w_w_hs      = s_wvalid && s_wready;
    assign w_r_hs      = s_rvalid && s_rready;
    assign w_last_beat = (r_cnt == r_len);
    assign w_addr_next = f_next_addr(r_addr, r_len, r_burst);
    assign w_ren       = w_ar_hs || (r_state == S_RDATA);
    assign w_raddr     = w_ar_hs ? s_araddr[ADDR_WIDTH+1:2] :
                         (w_r_hs && !w_last_beat) ? w_addr_next : r_addr;

    assign w_unused = ^{s_awsize, s_awlock, s_awcache, s_awprot, s_arsize,
                        s_arlock, s_arcache, s_arprot, s_wid,
                        s_awaddr[31:ADDR_WIDTH+2], s_awaddr[1:0],
                        s_araddr[31:ADDR_WIDTH+2], s_araddr[1:0]};

    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ar_hs)
                    w_next_state = S_RDATA;
                else if (w_aw_hs)
                    w_next_state = S_WDATA;
            end
            S_WDATA: if (w_w_hs && w_last_beat) w_next_state = S_WRESP;
            S_WRESP: if (s_bready) w_next_state = S_IDLE;
            S_RDATA: if (w_r_hs && w_last_beat) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        s_arready = (r_state == S_IDLE) && w_grant_rd;
        s_awready = (r_state == S_IDLE) && s_awvalid && !w_grant_rd;
        s_wready  = (r_state == S_WDATA);
        s_bvalid  = (r_state == S_WRESP);
        s_rvalid  = (r_state == S_RDATA);
        s_rlast   = (r_state == S_RDATA) && w_last_beat;
        s_bid     = r_id;
        s_rid     = r_id;
        s_bresp   = {r_err, 1'b0};
        s_rresp   = 2'b00;
        s_rdata   = r_rdata;
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            r_id      <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_prio_rd <= 1'b1;
        end else begin
            if (w_ar_hs || w_aw_hs) begin
                r_id      <= w_ar_hs ? s_arid : s_awid;
                r_cnt     <= '0;
                r_prio_rd <= w_aw_hs;
            end else if (w_w_hs || (w_r_hs && !w_last_beat)) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_aw_hs)
                r_err <= 1'b0;
            else if (w_w_hs && (s_wlast != w_last_beat))
                r_err <= 1'b1;
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (w_ar_hs) begin
            r_addr  <= s_araddr[ADDR_WIDTH+1:2];
            r_len   <= s_arlen;
            r_burst <= s_arburst;
        end else if (w_aw_hs) begin
            r_addr  <= s_awaddr[ADDR_WIDTH+1:2];
            r_len   <= s_awlen;
            r_burst <= s_awburst;
        end else if (w_w_hs || (w_r_hs && !w_last_beat)) begin
            r_addr  <= w_addr_next;
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (w_w_hs) begin
            for (int b = 0; b < 4; b++)
                if (s_wstrb[b])
                    r_mem[r_addr][8*b +: 8] <= s_wdata[8*b +: 8];
        end
    end

    // Read port is prefetched: the beat being accepted selects the next word.
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n)
            r_rdata <= '0;
        else if (w_ren)
            r_rdata <= r_mem[w_raddr];
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: a word-array model plus expected-beat
// queues checked every cycle, with literal expectations in the main sequence.
module tb_axi_ram_slave;

    logic        clk;
    logic        cpu_rst_n;
    logic [3:0]  s_awid, s_wid, s_bid, s_arid, s_rid;
    logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
    logic [7:0]  s_awlen, s_arlen;
    logic [2:0]  s_awsize, s_arsize, s_awprot, s_arprot;
    logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
    logic        s_awlock, s_arlock;
    logic [3:0]  s_awcache, s_arcache, s_wstrb;
    logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
    logic        s_bvalid, s_bready, s_arvalid, s_arready;
    logic        s_rlast, s_rvalid, s_rready;

    axi_ram_slave #(.ADDR_WIDTH(12), .ID_WIDTH(4)) dut (
        .cpu_clk_50M(clk), .cpu_rst_n(cpu_rst_n),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache),
        .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache),
        .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {logic [31:0] d; logic l; logic [3:0] id;} rexp_t;
    typedef struct {logic [3:0] id; logic [1:0] resp;} bexp_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mm [0:4095];
    rexp_t       rq[$];
    bexp_t       bq[$];
    rexp_t       mon_r;
    bexp_t       mon_b;
    logic [31:0] wd [0:15];
    logic [3:0]  ws [0:15];
    logic [31:0] got_rd [0:15];
    logic        got_last [0:15];
    logic [1:0]  last_bresp;
    logic [3:0]  last_bid;
    logic        hold;
    logic [31:0] h_data;
    logic        h_last;
    logic [3:0]  h_id;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Word index touched by beat i, straight from the burst rules.
    function automatic int model_word(input logic [31:0] addr, input int len,
                                      input logic [1:0] burst, input int i);
        int w;
        int n;
        w = int'((addr >> 2) & 32'hFFF);
        n = len + 1;
        if (burst == 2'b00) return w;
        if (burst == 2'b10 && (n == 2 || n == 4 || n == 8 || n == 16))
            return (w - (w % n)) + (((w % n) + i) % n);
        return (w + i) % 4096;
    endfunction

    always @(negedge clk) begin
        if (!cpu_rst_n) begin
            hold = 1'b0;
        end else begin
            if (s_awready || s_arready)
                chk("ready_exclusive", {31'd0, s_awready & s_arready}, 0);
            if (hold) begin
                chk("r_hold_valid", {31'd0, s_rvalid}, 1);
                chk("r_hold_data", s_rdata, h_data);
                chk("r_hold_last", {31'd0, s_rlast}, {31'd0, h_last});
                chk("r_hold_id", {28'd0, s_rid}, {28'd0, h_id});
            end
            if (s_rvalid && s_rready) begin
                chk("r_expected", {31'd0, rq.size() != 0}, 1);
                if (rq.size() != 0) begin
                    mon_r = rq.pop_front();
                    chk("r_data", s_rdata, mon_r.d);
                    chk("r_last", {31'd0, s_rlast}, {31'd0, mon_r.l});
                    chk("r_id", {28'd0, s_rid}, {28'd0, mon_r.id});
                    chk("r_resp", {30'd0, s_rresp}, 0);
                end
            end
            if (s_bvalid && s_bready) begin
                last_bresp = s_bresp;
                last_bid   = s_bid;
                chk("b_expected", {31'd0, bq.size() != 0}, 1);
                if (bq.size() != 0) begin
                    mon_b = bq.pop_front();
                    chk("b_id", {28'd0, s_bid}, {28'd0, mon_b.id});
                    chk("b_resp", {30'd0, s_bresp}, {30'd0, mon_b.resp});
                end
            end
            hold   = s_rvalid && !s_rready;
            h_data = s_rdata;
            h_last = s_rlast;
            h_id   = s_rid;
        end
    end

    task automatic wait_aw();
        int n = 0;
        @(negedge clk);
        while (!s_awready && n < 50) begin @(negedge clk); n++; end
        chk("aw_timeout", {31'd0, s_awready}, 1);
        @(posedge clk); #1;
        s_awvalid = 1'b0;
    endtask

    task automatic wait_ar();
        int n = 0;
        @(negedge clk);
        while (!s_arready && n < 50) begin @(negedge clk); n++; end
        chk("ar_timeout", {31'd0, s_arready}, 1);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input int wlast_at);
        int n;
        int idx;
        logic err = 1'b0;
        s_awid = id; s_awaddr = addr; s_awlen = 8'(len); s_awburst = burst; s_awvalid = 1'b1;
        wait_aw();
        for (int i = 0; i <= len; i++) begin
            s_wvalid = 1'b1; s_wdata = wd[i]; s_wstrb = ws[i]; s_wlast = (i == wlast_at);
            n = 0;
            @(negedge clk);
            while (!s_wready && n < 50) begin @(negedge clk); n++; end
            chk("w_timeout", {31'd0, s_wready}, 1);
            @(posedge clk); #1;
            idx = model_word(addr, len, burst, i);
            for (int b = 0; b < 4; b++)
                if (ws[i][b]) mm[idx][8*b +: 8] = wd[i][8*b +: 8];
            if ((i == wlast_at) != (i == len)) err = 1'b1;
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        bq.push_back('{id, err ? 2'b10 : 2'b00});
        s_bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_bvalid && n < 50) begin @(negedge clk); n++; end
        chk("b_timeout", {31'd0, s_bvalid}, 1);
        @(posedge clk); #1;
        s_bready = 1'b0;
    endtask

    // mode 0: rready held high; mode 1: rready 1,0,1,0,...
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input int mode);
        int k = 0;
        int done = 0;
        for (int i = 0; i <= len; i++)
            rq.push_back('{mm[model_word(addr, len, burst, i)], i == len, id});
        s_arid = id; s_araddr = addr; s_arlen = 8'(len); s_arburst = burst; s_arvalid = 1'b1;
        wait_ar();
        while (done <= len && k < 200) begin
            s_rready = (mode == 0) ? 1'b1 : (k % 2 == 0);
            @(negedge clk);
            if (k == 0) chk("rvalid_latency", {31'd0, s_rvalid}, 1);
            if (s_rvalid && s_rready) begin
                got_rd[done]   = s_rdata;
                got_last[done] = s_rlast;
                done++;
            end
            @(posedge clk); #1;
            k++;
        end
        s_rready = 1'b0;
        chk("r_beats", done, len + 1);
        @(negedge clk);
        chk("rvalid_after_last", {31'd0, s_rvalid}, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        cpu_rst_n = 1'b0;
        s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 3'b010; s_awburst = 2'b01;
        s_awlock = 0; s_awcache = 0; s_awprot = 0; s_awvalid = 0;
        s_wid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_wvalid = 0; s_bready = 0;
        s_arid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 3'b010; s_arburst = 2'b01;
        s_arlock = 0; s_arcache = 0; s_arprot = 0; s_arvalid = 0; s_rready = 0;
        hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", {31'd0, s_awready}, 0);
        chk("rst_arready", {31'd0, s_arready}, 0);
        chk("rst_wready", {31'd0, s_wready}, 0);
        chk("rst_bvalid", {31'd0, s_bvalid}, 0);
        chk("rst_rvalid", {31'd0, s_rvalid}, 0);
        chk("rst_rlast", {31'd0, s_rlast}, 0);
        chk("rst_bid", {28'd0, s_bid}, 0);
        chk("rst_rid", {28'd0, s_rid}, 0);
        chk("rst_rdata", s_rdata, 0);
        chk("rst_bresp", {30'd0, s_bresp}, 0);
        chk("rst_rresp", {30'd0, s_rresp}, 0);
        cpu_rst_n = 1'b1;
        @(posedge clk); #1;

        // single-beat write then read
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(4'h5, 32'h100, 0, 2'b01, 0);
        chk("t1_bresp", {30'd0, last_bresp}, 0);
        chk("t1_bid", {28'd0, last_bid}, 32'h5);
        chk("t1_model", mm[12'h040], 32'hDEADBEEF);
        do_read(4'h6, 32'h100, 0, 2'b01, 0);
        chk("t1_rdata", got_rd[0], 32'hDEADBEEF);
        chk("t1_rlast", {31'd0, got_last[0]}, 1);

        // INCR burst with rready toggling
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(4'h1, 32'h200, 3, 2'b01, 3);
        do_read(4'h2, 32'h200, 3, 2'b01, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t2_rdata", got_rd[i], 32'(i + 1));
            chk("t2_rlast", {31'd0, got_last[i]}, (i == 3) ? 1 : 0);
        end

        // WRAP read starting mid-window
        wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
        do_write(4'h3, 32'h200, 3, 2'b01, 3);
        do_read(4'h4, 32'h208, 3, 2'b10, 0);
        chk("t3_beat0", got_rd[0], 32'hC);
        chk("t3_beat1", got_rd[1], 32'hD);
        chk("t3_beat2", got_rd[2], 32'hA);
        chk("t3_beat3", got_rd[3], 32'hB);

        // byte strobes
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
        do_write(4'h2, 32'h500, 0, 2'b01, 0);
        wd[0] = 32'h11223344; ws[0] = 4'b0101;
        do_write(4'h2, 32'h500, 0, 2'b01, 0);
        do_read(4'h2, 32'h500, 0, 2'b01, 0);
        chk("t4_strobe", got_rd[0], 32'hFF22FF44);

        // early wlast: all beats still land, response is SLVERR
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h60 + 32'(i); ws[i] = 4'hF; end
        do_write(4'h7, 32'h600, 3, 2'b01, 2);
        chk("t5_bresp", {30'd0, last_bresp}, 32'h2);
        do_read(4'h7, 32'h600, 3, 2'b01, 0);
        chk("t5_beat3", got_rd[3], 32'h63);

        // FIXED read repeats one word
        do_read(4'h8, 32'h100, 1, 2'b00, 0);
        chk("fixed_b0", got_rd[0], 32'hDEADBEEF);
        chk("fixed_b1", got_rd[1], 32'hDEADBEEF);

        // reset during beat 2 of an 8-beat read
        for (int i = 0; i < 8; i++) begin wd[i] = 32'h1000 + 32'(i); ws[i] = 4'hF; end
        do_write(4'h9, 32'h400, 7, 2'b01, 7);
        rq.push_back('{32'h1000, 1'b0, 4'hA});
        rq.push_back('{32'h1001, 1'b0, 4'hA});
        s_arid = 4'hA; s_araddr = 32'h400; s_arlen = 8'd7; s_arburst = 2'b01; s_arvalid = 1'b1;
        wait_ar();
        s_rready = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk); @(posedge clk); #1;
        s_rready = 1'b0;
        cpu_rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t6_rvalid_rst", {31'd0, s_rvalid}, 0);
        chk("t6_rdata_rst", s_rdata, 0);
        cpu_rst_n = 1'b1;
        @(posedge clk); #1;
        do_read(4'hB, 32'h400, 7, 2'b01, 0);
        chk("t6_beat7", got_rd[7], 32'h1007);

        // arbitration after a fresh reset: read first, then write
        cpu_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cpu_rst_n = 1'b1;
        @(posedge clk); #1;
        rq.push_back('{32'hDEADBEEF, 1'b1, 4'h2});
        rq.push_back('{32'hDEADBEEF, 1'b1, 4'h3});
        s_awid = 4'h1; s_awaddr = 32'h300; s_awlen = 0; s_awburst = 2'b01; s_awvalid = 1'b1;
        s_arid = 4'h2; s_araddr = 32'h100; s_arlen = 0; s_arburst = 2'b01; s_arvalid = 1'b1;
        @(negedge clk);
        chk("arb1_arready", {31'd0, s_arready}, 1);
        chk("arb1_awready", {31'd0, s_awready}, 0);
        @(posedge clk); #1;
        s_arid = 4'h3;
        s_rready = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk);
        chk("arb2_awready", {31'd0, s_awready}, 1);
        chk("arb2_arready", {31'd0, s_arready}, 0);
        @(posedge clk); #1;
        s_awvalid = 1'b0;
        s_wvalid = 1'b1; s_wdata = 32'h33; s_wstrb = 4'hF; s_wlast = 1'b1;
        @(negedge clk);
        chk("arb_wready", {31'd0, s_wready}, 1);
        @(posedge clk); #1;
        mm[12'h0C0] = 32'h33;
        s_wvalid = 1'b0; s_wlast = 1'b0;
        bq.push_back('{4'h1, 2'b00});
        s_bready = 1'b1;
        @(negedge clk);
        chk("arb_bvalid", {31'd0, s_bvalid}, 1);
        @(posedge clk); #1;
        s_bready = 1'b0;
        @(negedge clk);
        chk("arb3_arready", {31'd0, s_arready}, 1);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        @(negedge clk);
        chk("arb3_rvalid", {31'd0, s_rvalid}, 1);
        @(posedge clk); #1;
        s_rready = 1'b0;
        do_read(4'hC, 32'h300, 0, 2'b01, 0);
        chk("arb_write_data", got_rd[0], 32'h33);

        repeat (2) @(posedge clk);
        chk("r_queue_drained", rq.size(), 0);
        chk("b_queue_drained", bq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
